// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program RAM sequencer that issues stored words to a small CPU and buffers its results
module program_sequencer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [3:0]   load_addr,
    input  logic [15:0]  load_data,
    input  logic [4:0]   prog_len,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         halted,
    output logic         cpu_rst,
    output logic [3:0]   opcode,
    output logic [n-1:0] address,
    output logic [7:0]   myinput,
    input  logic [7:0]   myoutput,
    input  logic         s_flag,
    input  logic         z_flag,
    input  logic         c_flag,
    input  logic [3:0]   rd_addr,
    output logic [10:0]  rd_data,
    output logic [4:0]   exec_count
);

    localparam logic [3:0] IDLE_OP = 4'b0110;
    localparam logic [3:0] HLT_OP  = 4'b1111;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t      state;
    logic [15:0] prog_mem [16];
    logic [10:0] res_mem  [16];

    logic [4:0]  run_len;
    logic [3:0]  cur_slot;
    logic        cur_hlt;
    logic        cur_last;
    logic        cur_iss;
    logic        wr_pend;
    logic [3:0]  wr_idx;

    logic [3:0]  nxt_slot;
    logic [15:0] nxt_word;
    logic        nxt_hlt;
    logic        nxt_last;

    assign load_ready = (state == IDLE);
    assign rd_data    = res_mem[rd_addr];

    // Look one slot ahead so the word for the next RUN cycle can be registered onto the CPU bus.
    always_comb begin
        nxt_slot = (state == CLEAR) ? 4'd0 : cur_slot + 4'd1;
        nxt_word = prog_mem[nxt_slot];
        nxt_hlt  = (nxt_word[15:12] == HLT_OP);
        nxt_last = (({1'b0, nxt_slot} + 5'd1) >= run_len);
    end

    // Program RAM write port, open only while idle.
    always_ff @(posedge clk) begin
        if (rst && load_valid && load_ready) begin
            prog_mem[load_addr] <= load_data;
        end
    end

    // Result capture: the CPU answer for a word arrives one cycle after it was issued.
    always_ff @(posedge clk) begin
        if (rst && wr_pend) begin
            res_mem[wr_idx] <= {c_flag, z_flag, s_flag, myoutput};
        end
    end

    // Run control FSM with registered CPU bus and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            exec_count <= 5'd0;
            cpu_rst    <= 1'b1;
            opcode     <= IDLE_OP;
            address    <= '0;
            myinput    <= 8'd0;
            run_len    <= 5'd16;
            cur_slot   <= 4'd0;
            cur_hlt    <= 1'b0;
            cur_last   <= 1'b0;
            cur_iss    <= 1'b0;
            wr_pend    <= 1'b0;
            wr_idx     <= 4'd0;
        end else begin
            done    <= 1'b0;
            cpu_rst <= 1'b0;
            wr_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        cpu_rst    <= 1'b1;
                        halted     <= 1'b0;
                        exec_count <= 5'd0;
                        cur_slot   <= 4'd0;
                        run_len    <= (prog_len == 5'd0 || prog_len > 5'd16) ? 5'd16 : prog_len;
                    end
                end
                CLEAR, RUN: begin
                    wr_pend <= (state == RUN) && cur_iss;
                    wr_idx  <= cur_slot;
                    if (state == RUN && (cur_hlt || cur_last)) begin
                        opcode  <= IDLE_OP;
                        address <= '0;
                        myinput <= 8'd0;
                        cur_iss <= 1'b0;
                        if (cur_hlt && cur_slot == 4'd0) begin
                            // nothing was issued, so there is no result left to drain
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        state    <= RUN;
                        cur_slot <= nxt_slot;
                        cur_hlt  <= nxt_hlt;
                        cur_last <= nxt_last;
                        if (nxt_hlt) begin
                            halted  <= 1'b1;
                            cur_iss <= 1'b0;
                            opcode  <= IDLE_OP;
                            address <= '0;
                            myinput <= 8'd0;
                        end else begin
                            cur_iss    <= 1'b1;
                            opcode     <= nxt_word[15:12];
                            address    <= n'(nxt_word[11:8]);
                            myinput    <= nxt_word[7:0];
                            exec_count <= exec_count + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
